// File: rtl/dma_axi_master.sv
// AXI4 DMA master: copies len_words words src->dst through a MAX_BURST-word line buffer, one burst in flight.
// len=0 completes 3 cycles after start; every AXI channel waits on its handshake, payload held while stalled.
module dma_axi_master #(
  parameter int                 MAX_BURST = 4,
  parameter int                 ID_BITS   = 4,
  parameter logic [ID_BITS-1:0] DMA_ID    = 4'd2
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [15:0]        len_words,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ID_BITS-1:0] ARID_M,
  output logic [31:0]        ARADDR_M,
  output logic [3:0]         ARLEN_M,
  output logic [2:0]         ARSIZE_M,
  output logic [1:0]         ARBURST_M,
  output logic               ARVALID_M,
  input  logic               ARREADY_M,
  input  logic [ID_BITS-1:0] RID_M,
  input  logic [31:0]        RDATA_M,
  input  logic [1:0]         RRESP_M,
  input  logic               RLAST_M,
  input  logic               RVALID_M,
  output logic               RREADY_M,
  output logic [ID_BITS-1:0] AWID_M,
  output logic [31:0]        AWADDR_M,
  output logic [3:0]         AWLEN_M,
  output logic [2:0]         AWSIZE_M,
  output logic [1:0]         AWBURST_M,
  output logic               AWVALID_M,
  input  logic               AWREADY_M,
  output logic [31:0]        WDATA_M,
  output logic [3:0]         WSTRB_M,
  output logic               WLAST_M,
  output logic               WVALID_M,
  input  logic               WREADY_M,
  input  logic [ID_BITS-1:0] BID_M,
  input  logic [1:0]         BRESP_M,
  input  logic               BVALID_M,
  output logic               BREADY_M
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int IDX_W = $clog2(MAX_BURST);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]      cur_src, cur_dst;
  logic [15:0]      remain;
  logic [CNT_W-1:0] beats, rbeat, wbeat;
  logic [31:0]      line_buf [MAX_BURST];
  logic [16:0]      room_src, room_dst, calc_beats;
  logic [3:0]       len_m1;
  logic             wlast;
  logic             unused;

  // Words left before the next 4KB boundary on each side.
  assign room_src = {4'd0, 13'h1000 - {1'b0, cur_src[11:0]}} >> 2;
  assign room_dst = {4'd0, 13'h1000 - {1'b0, cur_dst[11:0]}} >> 2;

  always_comb begin
    calc_beats = {1'b0, remain};
    if (calc_beats > 17'(MAX_BURST)) calc_beats = 17'(MAX_BURST);
    if (calc_beats > room_src) calc_beats = room_src;
    if (calc_beats > room_dst) calc_beats = room_dst;
  end

  assign len_m1 = 4'(beats - CNT_W'(1));
  assign wlast  = (wbeat == beats - CNT_W'(1));
  assign busy   = (state != S_IDLE);
  assign ARID_M = DMA_ID;
  assign AWID_M = DMA_ID;
  assign unused = ^{RID_M, BID_M, calc_beats[16:CNT_W]};

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ARVALID_M = 1'b0;
    ARADDR_M  = '0;
    ARLEN_M   = '0;
    ARSIZE_M  = '0;
    ARBURST_M = '0;
    RREADY_M  = 1'b0;
    AWVALID_M = 1'b0;
    AWADDR_M  = '0;
    AWLEN_M   = '0;
    AWSIZE_M  = '0;
    AWBURST_M = '0;
    WVALID_M  = 1'b0;
    WDATA_M   = '0;
    WSTRB_M   = '0;
    WLAST_M   = 1'b0;
    BREADY_M  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: state_nxt = (remain == 16'd0) ? S_DONE : S_AR;
      S_AR: begin
        ARVALID_M = 1'b1;
        ARADDR_M  = cur_src;
        ARLEN_M   = len_m1;
        ARSIZE_M  = 3'b010;
        ARBURST_M = 2'b01;
        if (ARREADY_M) state_nxt = S_R;
      end
      S_R: begin
        RREADY_M = 1'b1;
        // An error anywhere in the read burst aborts before any write traffic.
        if (RVALID_M && RLAST_M) state_nxt = (err || RRESP_M != 2'b00) ? S_DONE : S_AW;
      end
      S_AW: begin
        AWVALID_M = 1'b1;
        AWADDR_M  = cur_dst;
        AWLEN_M   = len_m1;
        AWSIZE_M  = 3'b010;
        AWBURST_M = 2'b01;
        if (AWREADY_M) state_nxt = S_W;
      end
      S_W: begin
        WVALID_M = 1'b1;
        WDATA_M  = line_buf[wbeat[IDX_W-1:0]];
        WSTRB_M  = 4'hF;
        WLAST_M  = wlast;
        if (WREADY_M && wlast) state_nxt = S_B;
      end
      S_B: begin
        BREADY_M = 1'b1;
        if (BVALID_M) state_nxt = (BRESP_M != 2'b00) ? S_DONE : S_CALC;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cur_src <= '0;
      cur_dst <= '0;
      remain  <= '0;
      beats   <= '0;
      rbeat   <= '0;
      wbeat   <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          cur_src <= src_addr;
          cur_dst <= dst_addr;
          remain  <= len_words;
          err     <= 1'b0;
        end
        S_CALC: begin
          beats <= calc_beats[CNT_W-1:0];
          rbeat <= '0;
          wbeat <= '0;
        end
        S_R: if (RVALID_M) begin
          rbeat <= rbeat + CNT_W'(1);
          if (RRESP_M != 2'b00) err <= 1'b1;
        end
        S_W: if (WREADY_M) wbeat <= wbeat + CNT_W'(1);
        S_B: if (BVALID_M) begin
          if (BRESP_M != 2'b00) err <= 1'b1;
          else begin
            cur_src <= cur_src + {{(30-CNT_W){1'b0}}, beats, 2'b00};
            cur_dst <= cur_dst + {{(30-CNT_W){1'b0}}, beats, 2'b00};
            remain  <= remain - {{(16-CNT_W){1'b0}}, beats};
          end
        end
        default: ;
      endcase
    end
  end

  // Extra beats from a misbehaving slave are dropped rather than wrapping the buffer.
  always_ff @(posedge ACLK) begin
    if (state == S_R && RVALID_M && rbeat < CNT_W'(MAX_BURST))
      line_buf[rbeat[IDX_W-1:0]] <= RDATA_M;
  end

endmodule

// File: tb/tb_dma_axi_master.sv
// Bench for dma_axi_master: randomised AXI slave with memory, burst-plan reference model and scoreboard.
module tb_dma_axi_master;
  localparam int MAXB = 4;

  logic        ACLK = 1'b0;
  logic        ARESET, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        busy, done, err;
  logic [3:0]  ARID_M, ARLEN_M, AWID_M, AWLEN_M, RID_M, BID_M, WSTRB_M;
  logic [31:0] ARADDR_M, AWADDR_M, RDATA_M, WDATA_M;
  logic [2:0]  ARSIZE_M, AWSIZE_M;
  logic [1:0]  ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
  logic        ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
  logic        AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;

  always #5 ACLK = ~ACLK;

  dma_axi_master #(.MAX_BURST(MAXB), .ID_BITS(4), .DMA_ID(4'd2)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .err(err),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
    .BREADY_M(BREADY_M)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_pct, rerr_beat, rd_beat_no, bq_n, ar_idx, aw_idx, done_cnt;
  logic [31:0] mem [int unsigned];
  logic [31:0] rq_addr[$], wq_addr[$], plan_src[$], plan_dst[$], exp_data[$];
  int          rq_left[$], wq_left[$], plan_beats[$];
  logic        r_hold, b_hold, ar_hold, aw_hold, w_hold, w_h_last, any_vld;
  logic [31:0] ar_h_addr, aw_h_addr, w_h_data;
  logic [3:0]  ar_h_len, aw_h_len;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd();
    return ($urandom_range(0, 99) < rdy_pct);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    if (mem.exists(k)) return mem[k];
    return 32'hDEAD_BEEF;
  endfunction

  // Reference burst plan: greedy bursts limited by remaining words, MAXB and both 4KB pages.
  task automatic build_plan(input logic [31:0] src, input logic [31:0] dst, input int len);
    longint s = src, d = dst, rem = len, b, room;
    plan_src.delete(); plan_dst.delete(); plan_beats.delete();
    while (rem > 0) begin
      b = (rem > MAXB) ? MAXB : rem;
      room = (4096 - (s % 4096)) / 4;
      if (b > room) b = room;
      room = (4096 - (d % 4096)) / 4;
      if (b > room) b = room;
      plan_src.push_back(32'(s)); plan_dst.push_back(32'(d)); plan_beats.push_back(int'(b));
      s += 4 * b; d += 4 * b; rem -= b;
    end
  endtask

  task automatic slave_reset();
    rq_addr.delete(); rq_left.delete(); wq_addr.delete(); wq_left.delete();
    bq_n = 0; r_hold = 0; b_hold = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
    ARREADY_M = 0; RVALID_M = 0; RDATA_M = 0; RRESP_M = 0; RLAST_M = 0; RID_M = 4'd2;
    AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0; BRESP_M = 0; BID_M = 4'd2;
  endtask

  // One slave cycle, evaluated just after the falling edge for the coming rising edge.
  task automatic slave_step();
    BVALID_M = b_hold || (bq_n > 0 && rnd());
    BRESP_M  = 2'b00;
    b_hold   = BVALID_M && !BREADY_M;
    if (BVALID_M && BREADY_M) bq_n--;

    if (rq_addr.size() > 0) begin
      RVALID_M = r_hold || rnd();
      RDATA_M  = mem_rd(rq_addr[0]);
      RLAST_M  = (rq_left[0] == 1);
      RRESP_M  = (rd_beat_no == rerr_beat) ? 2'b10 : 2'b00;
      r_hold   = RVALID_M && !RREADY_M;
      if (RVALID_M && RREADY_M) begin
        rd_beat_no++;
        rq_addr[0] = rq_addr[0] + 32'd4;
        rq_left[0] = rq_left[0] - 1;
        if (rq_left[0] == 0) begin void'(rq_addr.pop_front()); void'(rq_left.pop_front()); end
      end
    end else begin
      RVALID_M = 0; RLAST_M = 0; RDATA_M = 0; RRESP_M = 0; r_hold = 0;
    end

    if (ARVALID_M || AWVALID_M || WVALID_M) any_vld = 1;

    if (ar_hold) begin
      expect_eq("ar_valid_held", 32'(ARVALID_M), 1);
      expect_eq("ar_addr_held", ARADDR_M, ar_h_addr);
      expect_eq("ar_len_held", 32'(ARLEN_M), 32'(ar_h_len));
    end
    ARREADY_M = rnd();
    ar_hold = ARVALID_M && !ARREADY_M; ar_h_addr = ARADDR_M; ar_h_len = ARLEN_M;
    if (ARVALID_M && ARREADY_M) begin
      expect_eq("ar_outstanding", rq_addr.size() + wq_addr.size() + bq_n, 0);
      if (ar_idx < plan_src.size()) begin
        expect_eq("ar_addr", ARADDR_M, plan_src[ar_idx]);
        expect_eq("ar_len", 32'(ARLEN_M), plan_beats[ar_idx] - 1);
      end else expect_eq("ar_extra", ar_idx + 1, plan_src.size());
      expect_eq("ar_id_size_burst", {23'd0, ARID_M, ARSIZE_M, ARBURST_M}, {23'd0, 4'd2, 3'b010, 2'b01});
      expect_eq("ar_4k", 32'(((ARADDR_M % 4096) + 4 * (int'(ARLEN_M) + 1)) <= 4096), 1);
      rq_addr.push_back(ARADDR_M); rq_left.push_back(int'(ARLEN_M) + 1);
      ar_idx++;
    end

    if (aw_hold) begin
      expect_eq("aw_valid_held", 32'(AWVALID_M), 1);
      expect_eq("aw_addr_held", AWADDR_M, aw_h_addr);
      expect_eq("aw_len_held", 32'(AWLEN_M), 32'(aw_h_len));
    end
    AWREADY_M = rnd();
    aw_hold = AWVALID_M && !AWREADY_M; aw_h_addr = AWADDR_M; aw_h_len = AWLEN_M;
    if (AWVALID_M && AWREADY_M) begin
      expect_eq("aw_outstanding", rq_addr.size() + wq_addr.size() + bq_n, 0);
      if (aw_idx < plan_dst.size()) begin
        expect_eq("aw_addr", AWADDR_M, plan_dst[aw_idx]);
        expect_eq("aw_len", 32'(AWLEN_M), plan_beats[aw_idx] - 1);
      end else expect_eq("aw_extra", aw_idx + 1, plan_dst.size());
      expect_eq("aw_id_size_burst", {23'd0, AWID_M, AWSIZE_M, AWBURST_M}, {23'd0, 4'd2, 3'b010, 2'b01});
      wq_addr.push_back(AWADDR_M); wq_left.push_back(int'(AWLEN_M) + 1);
      aw_idx++;
    end

    if (w_hold) begin
      expect_eq("w_valid_held", 32'(WVALID_M), 1);
      expect_eq("w_data_held", WDATA_M, w_h_data);
      expect_eq("w_last_held", 32'(WLAST_M), 32'(w_h_last));
    end
    WREADY_M = rnd();
    w_hold = WVALID_M && !WREADY_M; w_h_data = WDATA_M; w_h_last = WLAST_M;
    if (WVALID_M && wq_addr.size() == 0) begin
      expect_eq("w_before_aw", wq_addr.size(), 1);
    end else if (WVALID_M && WREADY_M) begin
      expect_eq("w_strb", 32'(WSTRB_M), 32'hF);
      expect_eq("w_last", 32'(WLAST_M), 32'(wq_left[0] == 1));
      mem[wq_addr[0] >> 2] = WDATA_M;
      wq_addr[0] = wq_addr[0] + 32'd4;
      wq_left[0] = wq_left[0] - 1;
      if (wq_left[0] == 0) begin
        void'(wq_addr.pop_front()); void'(wq_left.pop_front());
        bq_n++;
      end
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    slave_step();
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int pct, input int rerr);
    int lat;
    logic busy_at_done, exp_err;
    logic [31:0] d;
    int exp_ar, exp_aw;
    slave_reset();
    rdy_pct = pct; rerr_beat = rerr; rd_beat_no = 0;
    ar_idx = 0; aw_idx = 0; any_vld = 0; done_cnt = 0;
    build_plan(src, dst, len);
    exp_data.delete();
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      exp_data.push_back(d);
      mem[(src >> 2) + 32'(i)] = d;
      mem[(dst >> 2) + 32'(i)] = ~d;
    end
    exp_err = (rerr >= 0);
    exp_ar  = exp_err ? 1 : plan_src.size();
    exp_aw  = exp_err ? 0 : plan_dst.size();

    src_addr = src; dst_addr = dst; len_words = 16'(len);
    start = 1'b1; lat = 0; busy_at_done = 1'b1;
    while (done_cnt == 0 && lat < 3000) begin
      tick();
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        expect_eq("busy_after_start", 32'(busy), 1);
        expect_eq("err_cleared_by_start", 32'(err), 0);
      end
      if (done_cnt > 0) busy_at_done = busy;
    end
    expect_eq("busy_drops_with_done", 32'(busy_at_done), 0);
    if (len == 0) begin
      expect_eq("len0_latency", lat, 3);
      expect_eq("len0_no_valid", 32'(any_vld), 0);
    end
    repeat (5) tick();
    expect_eq("done_once", done_cnt, 1);
    expect_eq("err_flag", 32'(err), 32'(exp_err));
    expect_eq("ar_bursts", ar_idx, exp_ar);
    expect_eq("aw_bursts", aw_idx, exp_aw);
    if (!exp_err) begin
      for (int i = 0; i < len; i++)
        expect_eq("dst_data", mem_rd(dst + 32'(4 * i)), exp_data[i]);
    end else if (len > 0) begin
      expect_eq("dst_untouched", mem_rd(dst), ~exp_data[0]);
    end
  endtask

  initial begin
    logic [31:0] s, t;
    logic found;
    ARESET = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
    rdy_pct = 100; rerr_beat = -1; rd_beat_no = 0; done_cnt = 0; any_vld = 0;
    ar_idx = 0; aw_idx = 0;
    slave_reset();
    repeat (3) tick();
    expect_eq("rst_busy_done_err", {29'd0, busy, done, err}, 0);
    expect_eq("rst_valid_ready", {26'd0, ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, WLAST_M}, 0);
    expect_eq("rst_araddr", ARADDR_M, 0);
    expect_eq("rst_awaddr", AWADDR_M, 0);
    expect_eq("rst_wdata", WDATA_M, 0);
    ARESET = 1'b0;
    tick();

    run_copy(32'h0000_0100, 32'h0001_0000, 8, 100, -1);
    run_copy(32'h0000_3000, 32'h0007_0000, 0, 100, -1);
    run_copy(32'h0000_0FF8, 32'h0002_0000, 6, 100, -1);
    run_copy(32'h0000_0200, 32'h0003_0000, 8, 100, 1);

    for (int n = 0; n < 6; n++) begin
      s = ($urandom_range(0, 15) << 12) +
          (($urandom_range(0, 1) != 0 ? $urandom_range(1018, 1023) : $urandom_range(0, 1023)) << 2);
      t = 32'h0010_0000 + ($urandom_range(0, 15) << 12) +
          (($urandom_range(0, 1) != 0 ? $urandom_range(1018, 1023) : $urandom_range(0, 1023)) << 2);
      run_copy(s, t, $urandom_range(1, 20), $urandom_range(30, 80), -1);
    end

    // Reset in the middle of the write burst, then a clean copy afterwards.
    slave_reset();
    rdy_pct = 60; rerr_beat = -1; rd_beat_no = 0; ar_idx = 0; aw_idx = 0;
    build_plan(32'h0000_0400, 32'h0005_0000, 8);
    for (int i = 0; i < 8; i++) mem[(32'h400 >> 2) + 32'(i)] = $urandom;
    src_addr = 32'h0000_0400; dst_addr = 32'h0005_0000; len_words = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      tick();
      if (WVALID_M) found = 1'b1;
    end
    expect_eq("reached_w_state", 32'(found), 1);
    ARESET = 1'b1;
    slave_reset();
    tick();
    expect_eq("rst_mid_valid_ready", {26'd0, ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, WLAST_M}, 0);
    expect_eq("rst_mid_busy", 32'(busy), 0);
    ARESET = 1'b0;
    slave_reset();
    tick();
    run_copy(32'h0000_0800, 32'h0006_0000, 4, 60, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
